tx_gearbox_40_10: RTL and testbench
===================================

// Module: tx_gearbox_40_10
// PURPOSE
//  Transmit-side gearbox feeding the lvds_tx30 serializer. Accepts one 40-bit word per
//  channel per 4-cycle frame (valid/ready) and emits it as four 10-bit slices,
//  low slice first, so the far-end receiver's 10->40 demux rebuilds the word in order.
//  Inserts a training pattern after reset or on request, for receiver channel data
//  alignment. Idle words are sent when no data is pending.
// PARAMETERS
//  NCH        30        number of LVDS channels
//  TRAIN_PAT  10'h3E0   10-bit pattern sent in every slice during training
//  TRAIN_WRDS 256       training length in 4-cycle frames (>=1)
//  IDLE_WORD  40'h0     per-channel word sent when no data is pending
// PORTS
//  I_clk          in   1        serializer parallel clock; single clock domain
//  I_rst_n        in   1        reset, synchronous, active-low
//  I_data         in   NCH*40   channel k word at [40k+39:40k]
//  I_valid        in   1        I_data is valid
//  O_ready        out  1        word accepted at edge where I_valid & O_ready
//  I_train_req    in   1        rising edge requests retraining
//  O_tx_data      out  NCH*10   to serializer tx_in; channel k at [10k+9:10k]
//  O_frame        out  1        high while O_tx_data carries slice 0
//  O_training     out  1        high while training slices are driven
//  O_train_done   out  1        one-cycle pulse at end of training
// BEHAVIOUR
//  - Reset (I_rst_n=0 at an edge): phase=0, buffer empty, state=TRAIN, train count=0,
//    O_tx_data=0, O_frame=0, O_training=0, O_train_done=0. Mid-operation reset
//    drops the buffered and in-flight words with no partial-word flush.
//  - phase: 2-bit counter, +1 every cycle, wraps 3->0. Frame boundary = edge with phase==3.
//  - Buffer: one entry of NCH*40 bits. O_ready = state==RUN & (!buf_full | drain).
//    drain = phase==3 & buf_full & state==RUN. Accept and drain may occur at the
//    same edge; the buffer then holds the new word.
//  - Shift register load at every frame boundary: TRAIN -> {4{TRAIN_PAT}} per channel;
//    RUN & buf_full -> buffer; otherwise IDLE_WORD.
//  - O_tx_data is registered. At phase p it carries slice p of the loaded word:
//    p=0 -> [9:0] ... p=3 -> [39:30]. O_frame=1 exactly when slice 0 is shown.
//  - Latency: the word accepted at edge e appears as slice 0 on the first O_frame
//    cycle after the first frame boundary strictly later than e. That is 2..5
//    cycles, or 1 frame longer when the buffer is already occupied.
//  - FSM TRAIN: O_ready=0. The buffer is held and not discarded. Count frames.
//    After TRAIN_WRDS frames -> RUN, with O_train_done=1 for the single cycle on
//    which the first post-training slice 0 is shown.
//  - FSM RUN: a rising edge of I_train_req, registered, takes effect at the next
//    frame boundary -> TRAIN, with count=0. A request arriving while already in
//    TRAIN is ignored; the count is not restarted.
//  - O_training=1 exactly on cycles whose slice comes from the training pattern.
//  - Simultaneous training request and pending buffer: training wins, and the
//    buffered word is sent first after training ends.
//  - Words are never split, reordered, or duplicated across a TRAIN/RUN transition.
// STRUCTURE
//  - Package tx_gearbox_pkg holds: slice width 10, word width 40,
//    SLICES_PER_WORD 4, and the state typedef {TRAIN, RUN}.
//  - Sub-module tx_gearbox_lane holds one channel's 40-bit shift register and
//    slice mux. It is instantiated NCH times by generate. The top level owns the
//    phase counter, FSM, buffer flags, and handshake.
// TESTING
//  1 Reset then idle: I_valid=0, TRAIN_WRDS=4. Expect 16 cycles of 10'h3E0 on all
//    channels, O_training=1. Then one O_train_done pulse, then IDLE_WORD slices.
//  2 Single word: ch0=40'hAAAAA_55555 in RUN. ch0 slices in order: 10'h155, 10'h155,
//    10'h2AA, 10'h2AA. O_frame is high on the first.
//  3 Back-to-back: I_valid=1 constantly with incrementing words. O_ready duty is
//    1 per 4 cycles. The output has no idle frame, and order is preserved.
//  4 Training request while the buffer is full: the held word appears on the first
//    frame after TRAIN_WRDS training frames, intact.
//  5 Reset asserted at phase 2 mid-word: the next cycle shows O_tx_data=0 and
//    O_ready=0, and training restarts from count 0.
//  6 Loopback via the rx30_io40 model: a random 1000-word stream is received
//    bit-exact after CDA alignment completes during training.

Source files
------------

// File: rtl/tx_gearbox_pkg.sv
// Shared widths, FSM state and shift-register load selector for the 40->10 transmit gearbox.
package tx_gearbox_pkg;

    localparam int SLICE_W         = 10;
    localparam int WORD_W          = 40;
    localparam int SLICES_PER_WORD = 4;

    typedef enum logic {
        TRAIN = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        LOAD_IDLE  = 2'd0,
        LOAD_TRAIN = 2'd1,
        LOAD_BUF   = 2'd2
    } load_sel_e;

endpackage

// File: rtl/tx_gearbox_lane.sv
// One channel: picks the 40-bit word to load at a frame boundary, then emits it
// as four registered 10-bit slices, low slice first.
module tx_gearbox_lane
    import tx_gearbox_pkg::*;
#(
    parameter logic [SLICE_W-1:0] TRAIN_PAT = 10'h3E0,
    parameter logic [WORD_W-1:0]  IDLE_WORD = 40'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  load_sel_e          load_sel,
    input  logic [WORD_W-1:0]  buf_word,
    output logic [SLICE_W-1:0] slice
);

    logic [WORD_W-1:0]         load_word;
    logic [WORD_W-SLICE_W-1:0] sh_q, sh_d;
    logic [SLICE_W-1:0]        slice_q, slice_d;

    always_comb begin
        load_word = IDLE_WORD;
        case (load_sel)
            LOAD_TRAIN: load_word = {SLICES_PER_WORD{TRAIN_PAT}};
            LOAD_BUF:   load_word = buf_word;
            default:    load_word = IDLE_WORD;
        endcase

        // slice 0 goes straight to the output; the upper three wait in sh_q
        sh_d    = {{SLICE_W{1'b0}}, sh_q[WORD_W-SLICE_W-1:SLICE_W]};
        slice_d = sh_q[SLICE_W-1:0];
        if (load) begin
            slice_d = load_word[SLICE_W-1:0];
            sh_d    = load_word[WORD_W-1:SLICE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q    <= '0;
            slice_q <= '0;
        end else begin
            sh_q    <= sh_d;
            slice_q <= slice_d;
        end
    end

    assign slice = slice_q;

endmodule

// File: rtl/tx_gearbox_40_10.sv
// Transmit gearbox: one 40-bit word per channel per 4-cycle frame in, four 10-bit
// slices out, with a training phase after reset or on request.
module tx_gearbox_40_10
    import tx_gearbox_pkg::*;
#(
    parameter int                 NCH        = 30,
    parameter logic [SLICE_W-1:0] TRAIN_PAT  = 10'h3E0,
    parameter int                 TRAIN_WRDS = 256,
    parameter logic [WORD_W-1:0]  IDLE_WORD  = 40'h0
) (
    input  logic                     I_clk,
    input  logic                     I_rst_n,
    input  logic [NCH*WORD_W-1:0]    I_data,
    input  logic                     I_valid,
    output logic                     O_ready,
    input  logic                     I_train_req,
    output logic [NCH*SLICE_W-1:0]   O_tx_data,
    output logic                     O_frame,
    output logic                     O_training,
    output logic                     O_train_done,
    output state_e                   O_dbg_state
);

    localparam int              CNT_W    = (TRAIN_WRDS > 1) ? $clog2(TRAIN_WRDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAIN_WRDS - 1);

    // Handshake: a word transfers on every rising I_clk where I_valid && O_ready;
    // I_data must be stable while I_valid is high and O_ready is low.

    logic [1:0]            phase_q, phase_d;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  buf_full_q, buf_full_d;
    logic [NCH*WORD_W-1:0] buf_q, buf_d;
    logic                  req_prev_q, req_prev_d;
    logic                  pend_q, pend_d;
    logic                  just_trained_q, just_trained_d;
    logic                  frame_q, frame_d;
    logic                  training_q, training_d;
    logic                  done_q, done_d;

    logic                  boundary;
    logic                  train_frame;
    logic                  drain;
    logic                  accept;
    logic [CNT_W-1:0]      train_idx;
    load_sel_e             load_sel;

    assign boundary    = (phase_q == 2'd3);
    // a pending request claims the boundary, so the buffered word waits out training
    assign train_frame = boundary & ((state_q == TRAIN) | pend_q);
    assign drain       = boundary & buf_full_q & (state_q == RUN) & ~pend_q;
    assign O_ready     = (state_q == RUN) & (~buf_full_q | drain);
    assign accept      = I_valid & O_ready;
    assign load_sel    = train_frame ? LOAD_TRAIN : (buf_full_q ? LOAD_BUF : LOAD_IDLE);

    always_comb begin
        phase_d        = phase_q + 2'd1;
        state_d        = state_q;
        cnt_d          = cnt_q;
        buf_d          = buf_q;
        buf_full_d     = buf_full_q;
        req_prev_d     = I_train_req;
        pend_d         = pend_q;
        just_trained_d = just_trained_q;
        frame_d        = boundary;
        training_d     = training_q;
        done_d         = 1'b0;
        train_idx      = (state_q == TRAIN) ? cnt_q : '0;

        if ((state_q == RUN) && I_train_req && !req_prev_q)
            pend_d = 1'b1;

        if (drain)
            buf_full_d = 1'b0;
        if (accept) begin
            buf_d      = I_data;
            buf_full_d = 1'b1;
        end

        if (boundary) begin
            training_d     = train_frame;
            done_d         = just_trained_q & ~train_frame;
            just_trained_d = 1'b0;
            if (train_frame) begin
                pend_d = 1'b0;
                // train_idx counts training frames already loaded in this run
                if (train_idx == CNT_LAST) begin
                    state_d        = RUN;
                    cnt_d          = '0;
                    just_trained_d = 1'b1;
                end else begin
                    state_d = TRAIN;
                    cnt_d   = train_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            phase_q        <= '0;
            state_q        <= TRAIN;
            cnt_q          <= '0;
            buf_full_q     <= 1'b0;
            req_prev_q     <= 1'b0;
            pend_q         <= 1'b0;
            just_trained_q <= 1'b0;
            frame_q        <= 1'b0;
            training_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            buf_full_q     <= buf_full_d;
            req_prev_q     <= req_prev_d;
            pend_q         <= pend_d;
            just_trained_q <= just_trained_d;
            frame_q        <= frame_d;
            training_q     <= training_d;
            done_q         <= done_d;
        end
    end

    // buffer contents are qualified by buf_full_q, so they need no reset
    always_ff @(posedge I_clk) begin
        buf_q <= buf_d;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        tx_gearbox_lane #(
            .TRAIN_PAT (TRAIN_PAT),
            .IDLE_WORD (IDLE_WORD)
        ) u_lane (
            .clk      (I_clk),
            .rst_n    (I_rst_n),
            .load     (boundary),
            .load_sel (load_sel),
            .buf_word (buf_q[k*WORD_W +: WORD_W]),
            .slice    (O_tx_data[k*SLICE_W +: SLICE_W])
        );
    end

    assign O_frame      = frame_q;
    assign O_training   = training_q;
    assign O_train_done = done_q;
    assign O_dbg_state  = state_q;

endmodule

// File: tb/tb_tx_gearbox_40_10.sv
// Directed bench for tx_gearbox_40_10: frame monitor rebuilds words from slices
// and checks them against the queue of accepted words.
module tb_tx_gearbox_40_10;
  import tx_gearbox_pkg::*;

  localparam int NCH        = 4;
  localparam int TRAIN_WRDS = 4;
  localparam logic [9:0] TRAIN_PAT = 10'h3E0;
  localparam int W  = NCH * 40;
  localparam int SW = NCH * 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  data = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic          train_req = 1'b0;
  logic [SW-1:0] tx_data;
  logic          frame;
  logic          training;
  logic          train_done;
  state_e        dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  int           idx = -1;
  logic [W-1:0] fr_word = '0;
  logic         fr_train = 1'b0;
  logic         fr_done = 1'b0;
  logic         prev_train = 1'b0;
  int           train_run = 0;
  int           last_train_len = 0;
  logic [W-1:0] post_train_word = '0;
  int           done_cnt = 0;
  logic         burst_armed = 1'b0;
  logic         burst_seen = 1'b0;
  int           idle_gaps = 0;
  int           last_acc = 0;
  int           last_acc_prev = 0;
  logic [W-1:0]  train_word;
  logic [SW-1:0] train_slices;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tx_gearbox_40_10 #(
    .NCH        (NCH),
    .TRAIN_PAT  (TRAIN_PAT),
    .TRAIN_WRDS (TRAIN_WRDS),
    .IDLE_WORD  (40'h0)
  ) dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_data       (data),
    .I_valid      (valid),
    .O_ready      (ready),
    .I_train_req  (train_req),
    .O_tx_data    (tx_data),
    .O_frame      (frame),
    .O_training   (training),
    .O_train_done (train_done),
    .O_dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    r[0] = 1'b1;
    return r;
  endfunction

  // ---------------- scoreboard / frame monitor ----------------
  task automatic eval_frame();
    if (fr_train) begin
      check("train_frame_word", fr_word, train_word);
      train_run++;
    end else begin
      check("done_with_first_post_train_frame", fr_done, prev_train);
      if (prev_train) begin
        last_train_len  = train_run;
        train_run       = 0;
        post_train_word = fr_word;
      end
      if (fr_word == '0) begin
        if (burst_armed && burst_seen && exp_q.size() > 0) idle_gaps++;
      end else if (exp_q.size() == 0) begin
        check("unexpected_word", fr_word, '0);
      end else begin
        check("sb_word", fr_word, exp_q.pop_front());
        if (burst_armed) burst_seen = 1'b1;
      end
    end
    prev_train = fr_train;
  endtask

  always @(negedge clk) begin
    if (train_done) done_cnt++;
    if (!rst_n) begin
      idx = -1;
    end else begin
      if (frame) begin
        idx      = 0;
        fr_train = training;
        fr_done  = train_done;
        fr_word  = '0;
      end else if (idx >= 0) begin
        idx++;
      end
      if (idx >= 0) begin
        for (int k = 0; k < NCH; k++) fr_word[k*40 + idx*10 +: 10] = tx_data[k*10 +: 10];
        if (idx == 3) begin
          eval_frame();
          idx = -1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    data  = w;
    valid = 1'b1;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_within_budget", ready, 1'b1);
    if (ready) begin
      exp_q.push_back(w);
      last_acc_prev = last_acc;
      last_acc      = cyc;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // called at the negedge where rst_n is released
  task automatic check_training_run();
    int k;
    k = 0;
    while (!training && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("train_start_delay", k, 4);
    check("ready_low_in_train", ready, 1'b0);
    for (int i = 0; i < 4 * TRAIN_WRDS; i++) begin
      check("train_flag", training, 1'b1);
      check("train_data", tx_data, train_slices);
      check("train_frame_pos", frame, (i % 4) == 0);
      check("train_no_done", train_done, 1'b0);
      @(negedge clk);
    end
    check("done_pulse", train_done, 1'b1);
    check("post_train_flag", training, 1'b0);
    check("post_train_frame", frame, 1'b1);
    check("post_train_idle", tx_data, '0);
    @(negedge clk);
    check("done_one_cycle", train_done, 1'b0);
    check("state_run", dbg_state, RUN);
  endtask

  // ---------------- directed steps ----------------
  initial begin
    logic [W-1:0] w;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int k;
    int d0;

    for (int i = 0; i < NCH * 4; i++) train_word[i*10 +: 10] = TRAIN_PAT;
    for (int i = 0; i < NCH; i++) train_slices[i*10 +: 10] = TRAIN_PAT;

    // 1: reset, then training with no traffic
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", tx_data, '0);
    check("rst_frame", frame, 1'b0);
    check("rst_training", training, 1'b0);
    check("rst_done", train_done, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_state", dbg_state, TRAIN);
    rst_n = 1'b1;
    check_training_run();
    for (int i = 0; i < 4; i++) begin
      check("idle_data", tx_data, '0);
      check("idle_training", training, 1'b0);
      @(negedge clk);
    end

    // 2: single word, slice order and latency
    w = rand_word();
    w[39:0] = 40'hAAAAA_55555;
    send(w);
    k = 1;
    while (!(frame && !training && tx_data[9:0] != 10'h0) && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("single_latency_in_range", (k >= 2 && k <= 5), 1'b1);
    check("single_s0", tx_data[9:0], 10'h155);
    check("single_frame_s0", frame, 1'b1);
    @(negedge clk);
    check("single_s1", tx_data[9:0], 10'h155);
    check("single_frame_s1", frame, 1'b0);
    @(negedge clk);
    check("single_s2", tx_data[9:0], 10'h2AA);
    @(negedge clk);
    check("single_s3", tx_data[9:0], 10'h2AA);
    wait_drain();

    // 3: back-to-back stream
    burst_armed = 1'b1;
    burst_seen  = 1'b0;
    idle_gaps   = 0;
    for (int i = 0; i < 12; i++) begin
      send(rand_word());
      if (i >= 2) check("btb_ready_period", last_acc - last_acc_prev, 4);
    end
    wait_drain();
    check("btb_no_idle_frame", idle_gaps, 0);
    burst_armed = 1'b0;

    // 4: retrain with a word held in the buffer; a second request mid-training is ignored
    a = rand_word();
    b = rand_word();
    d0 = done_cnt;
    send(a);
    send(b);
    train_req = 1'b1;
    k = 0;
    while (!training && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("retrain_started", training, 1'b1);
    check("retrain_ready_low", ready, 1'b0);
    repeat (5) @(negedge clk);
    train_req = 1'b0;
    @(negedge clk);
    train_req = 1'b1;
    repeat (2) @(negedge clk);
    train_req = 1'b0;
    wait_drain();
    check("retrain_len", last_train_len, TRAIN_WRDS);
    check("held_word_first_after_train", post_train_word, b);
    check("retrain_done_count", done_cnt - d0, 1);

    // 5: reset in the middle of a word
    w = rand_word();
    send(w);
    k = 0;
    while (!(frame && !training && tx_data != '0) && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("midword_frame_seen", frame, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx_data", tx_data, '0);
    check("midrst_ready", ready, 1'b0);
    check("midrst_frame", frame, 1'b0);
    check("midrst_training", training, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_training_run();

    // 6: random stream with random gaps
    for (int i = 0; i < 40; i++) begin
      send(rand_word());
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_drain();

    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
